ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB2 responder: a word-wide SRAM target on the shared AHB bus that our master driver and monitors talk to.
- Decodes address/control phases and inserts a configurable number of wait states.
- Commits writes with byte lanes and returns read data.
- Issues the two-cycle ERROR response for illegal accesses.
- Never generates RETRY or SPLIT.

Parameters:
ADDR_W, 12, byte-address bits decoded inside the region; depth is 2^(ADDR_W-2) words.
BASE, 32'h0000_0000, region base; HADDR[31:ADDR_W] must equal BASE[31:ADDR_W].
WAIT_STATES, 0, HREADYOUT-low cycles per OKAY data phase (0..7).

Ports:
HCLK  in  1  bus clock; everything is on its rising edge.
HRESETn  in  1  synchronous, active-low reset.
HSEL  in  1  slave select from decoder.
HREADY  in  1  bus-level ready; qualifies the address phase.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HBURST  in  3  unused; present for interface completeness.
HSIZE  in  3  transfer size.
HWRITE  in  1  1 = write.
HADDR  in  32  byte address.
HWDATA  in  32  write data, valid in data phase.
HREADYOUT  out  1  slave ready.
HRESP  out  2  OKAY=0 or ERROR=1 only.
HRDATA  out  32  read data.

Behaviour:
Reset (HRESETn low at an edge):
- State goes to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
- Memory contents are neither cleared nor initialised.

Address phase accept:
- Accept when HSEL && HREADY && HTRANS[1] at a rising edge.
- Register HADDR, HSIZE and HWRITE into addr_q, size_q and write_q.
- IDLE or BUSY transfers, and any cycle with HSEL low, produce no data phase and respond OKAY with zero wait.
- Address phases seen while HREADY=0 are ignored.

Error check, evaluated at accept:
- HSIZE>2 is illegal.
- HSIZE=1 with HADDR[0]=1 is illegal.
- HSIZE=2 with HADDR[1:0]!=0 is illegal.
- An out-of-region address is illegal.

State machine (IDLE, WAIT, ERR1, ERR2):
- IDLE, legal accept: if WAIT_STATES=0, stay in data phase with HREADYOUT=1; else go to WAIT, load wcnt=WAIT_STATES-1, HREADYOUT=0, HRESP=0.
- WAIT: decrement wcnt; HREADYOUT=1 in the cycle after wcnt hits 0.
- Illegal accept goes to ERR1: HREADYOUT=0, HRESP=1.
- ERR1 goes to ERR2: HREADYOUT=1, HRESP=1.
- ERR2 goes to IDLE, or to a new data phase if a new address phase is accepted in ERR2.

Pipelining:
- A new address phase accepted in the final data-phase cycle (HREADYOUT=1) starts its data phase on the next cycle.
- Back-to-back zero-wait transfers sustain one beat per cycle.

Write:
- Commit at the edge ending the data phase (HREADYOUT=1, OKAY).
- Byte enables are little-endian from size_q and addr_q[1:0]:
  - byte: 1<<a[1:0]
  - half: 3<<{a[1],0}
  - word: 4'hF
- An errored write never modifies memory.

Read:
- HRDATA = mem[addr_q[ADDR_W-1:2]] (full word, lanes unshifted) while HREADYOUT=1 in an OKAY read data phase.
- HRDATA = 0 otherwise.

Hazard:
- A write followed immediately by a read of the same word returns the new data, because the write commits before the read data phase.

Reset mid-transfer:
- Abandon the data phase and return to IDLE outputs.
- A pending write is not committed.

Decomposition:
- ahb_pkg holds:
  - htrans_e, hresp_e and hsize_e enums.
  - slave_state_e {IDLE, WAIT, ERR1, ERR2}.
  - A byte-enable decode function.
- One sub-module, ahb_sram_array: a word array with a 4-bit byte write enable, a write port and an asynchronous read port.

Test Plan:
1. Reset: HRESETn=0 for 2 cycles with random bus activity -> HREADYOUT=1, HRESP=0, HRDATA=0.
2. WAIT_STATES=0: NONSEQ word write 0x10 / 0xDEADBEEF, then NONSEQ read 0x10 -> read data phase HRDATA=0xDEADBEEF; HREADYOUT=1 on every cycle.
3. Word 0x10 holds 0x11223344; byte write 0xAB to 0x13, then halfword write 0x5566 to 0x10 -> read 0x10 returns 0xAB225566.
4. WAIT_STATES=2: INCR4 word read from 0x20 -> each beat shows 2 cycles HREADYOUT=0 then 1; burst completes in 12 cycles, HRESP=0 throughout.
5. Word write to 0x22 with 0xFFFFFFFF -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE gives HRESP=0; word 0x20 is unchanged. An address outside BASE behaves the same.
6. WAIT_STATES=3: write 0x40 / 0x12345678, HRESETn=0 during the second wait cycle -> next cycle HREADYOUT=1, HRESP=0; subsequent read of 0x40 returns the prior contents.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB2 types, widths and the byte-lane decode used by the SRAM responder.
package ahb_pkg;

    localparam int unsigned HADDR_W = 32;
    localparam int unsigned HDATA_W = 32;
    localparam int unsigned WCNT_W  = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } slave_state_e;

    // Little-endian lane enables for a legal (aligned) transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'(4'b0001 << a);
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'hF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB2 slave-side signal bundle; clock and reset stay outside.
interface ahb_sram_slave_if;
    import ahb_pkg::*;

    logic               HSEL;
    logic               HREADY;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic [2:0]         HSIZE;
    logic               HWRITE;
    logic [HADDR_W-1:0] HADDR;
    logic [HDATA_W-1:0] HWDATA;
    logic               HREADYOUT;
    logic [1:0]         HRESP;
    logic [HDATA_W-1:0] HRDATA;

    modport slave (
        input  HSEL, HREADY, HTRANS, HBURST, HSIZE, HWRITE, HADDR, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HREADY, HTRANS, HBURST, HSIZE, HWRITE, HADDR, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_sram_array.sv
// Word array with per-byte write enables and an asynchronous read port.
module ahb_sram_array #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_c
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB2 SRAM responder: wait-state insertion, byte-lane writes, two-cycle ERROR.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned  ADDR_W      = 12,
    parameter logic [31:0]  BASE        = 32'h0000_0000,
    parameter int unsigned  WAIT_STATES = 0
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_ERR1 = ERR1;
    localparam logic [1:0] S_ERR2 = ERR2;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [1:0]        state_q, state_n;
    logic              dphase_q, dphase_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [2:0]        size_q, size_n;
    logic              write_q, write_n;
    logic [WCNT_W-1:0] wcnt_q, wcnt_n;
    logic              hreadyout_q, hreadyout_n;
    logic [1:0]        hresp_q, hresp_n;
    logic [31:0]       hrdata_q, hrdata_n;

    logic               accept_c, illegal_c, commit_c, same_word_c;
    logic [3:0]         be_c;
    logic [WORD_AW-1:0] raddr_c;
    logic [31:0]        rdata_c, fwd_c;
    logic               unused_c;

    assign unused_c = ^{bus.HBURST, bus.HTRANS[0]};

    assign accept_c  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign illegal_c = (bus.HSIZE > 3'd2)
                    || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
                    || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
                    || (bus.HADDR[31:ADDR_W] != BASE[31:ADDR_W]);

    // The final data-phase cycle of a legal transfer always sits in IDLE.
    assign commit_c = (state_q == S_IDLE) && dphase_q && write_q && HRESETn;
    assign be_c     = commit_c ? byte_en(size_q, addr_q[1:0]) : 4'h0;
    assign raddr_c  = (state_q == S_WAIT) ? addr_q[ADDR_W-1:2] : bus.HADDR[ADDR_W-1:2];
    assign same_word_c = (addr_q[ADDR_W-1:2] == bus.HADDR[ADDR_W-1:2]);

    ahb_sram_array #(.AW(WORD_AW)) u_array (
        .clk     (HCLK),
        .we      (be_c),
        .waddr   (addr_q[ADDR_W-1:2]),
        .wdata   (bus.HWDATA),
        .raddr   (raddr_c),
        .rdata_c (rdata_c)
    );

    // Zero-wait read right behind a write to the same word sees the new lanes.
    always_comb begin
        fwd_c = rdata_c;
        for (int i = 0; i < 4; i++) begin
            if (be_c[i] && same_word_c) fwd_c[8*i +: 8] = bus.HWDATA[8*i +: 8];
        end
    end

    always_comb begin
        state_n     = state_q;
        dphase_n    = dphase_q;
        addr_n      = addr_q;
        size_n      = size_q;
        write_n     = write_q;
        wcnt_n      = wcnt_q;
        hreadyout_n = 1'b1;
        hresp_n     = 2'(HRESP_OKAY);
        hrdata_n    = 32'h0;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_n  = S_IDLE;
                    hrdata_n = write_q ? 32'h0 : rdata_c;
                end else begin
                    wcnt_n      = wcnt_q - WCNT_W'(1);
                    hreadyout_n = 1'b0;
                end
            end
            S_ERR1: begin
                state_n = S_ERR2;
                hresp_n = 2'(HRESP_ERROR);
            end
            default: begin
                state_n  = S_IDLE;
                dphase_n = 1'b0;
                if (accept_c) begin
                    addr_n  = bus.HADDR[ADDR_W-1:0];
                    size_n  = bus.HSIZE;
                    write_n = bus.HWRITE;
                    if (illegal_c) begin
                        state_n     = S_ERR1;
                        hreadyout_n = 1'b0;
                        hresp_n     = 2'(HRESP_ERROR);
                    end else if (WAIT_STATES == 0) begin
                        dphase_n = 1'b1;
                        hrdata_n = bus.HWRITE ? 32'h0 : fwd_c;
                    end else begin
                        state_n     = S_WAIT;
                        dphase_n    = 1'b1;
                        wcnt_n      = WCNT_LOAD;
                        hreadyout_n = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            dphase_q    <= 1'b0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            write_q     <= 1'b0;
            wcnt_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'(HRESP_OKAY);
            hrdata_q    <= 32'h0;
        end else begin
            state_q     <= state_n;
            dphase_q    <= dphase_n;
            addr_q      <= addr_n;
            size_q      <= size_n;
            write_q     <= write_n;
            wcnt_q      <= wcnt_n;
            hreadyout_q <= hreadyout_n;
            hresp_q     <= hresp_n;
            hrdata_q    <= hrdata_n;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three responders with 0, 2 and 3 wait states on one clock.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        hsel   [3];
    logic [1:0]  htrans [3];
    logic [2:0]  hburst [3];
    logic [2:0]  hsize  [3];
    logic        hwrite [3];
    logic [31:0] haddr  [3];
    logic [31:0] hwdata [3];
    logic        hro    [3];
    logic [1:0]  hresp  [3];
    logic [31:0] hrdata [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave_if bus ();
        assign bus.HSEL   = hsel[g];
        assign bus.HTRANS = htrans[g];
        assign bus.HBURST = hburst[g];
        assign bus.HSIZE  = hsize[g];
        assign bus.HWRITE = hwrite[g];
        assign bus.HADDR  = haddr[g];
        assign bus.HWDATA = hwdata[g];
        assign bus.HREADY = bus.HREADYOUT;
        assign hro[g]     = bus.HREADYOUT;
        assign hresp[g]   = bus.HRESP;
        assign hrdata[g]  = bus.HRDATA;

        ahb_sram_slave #(
            .ADDR_W      (12),
            .BASE        (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .bus     (bus)
        );
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = 2'(HTRANS_IDLE);
        hburst[k] = 3'd0;
        hsize[k]  = 3'd0;
        hwrite[k] = 1'b0;
        haddr[k]  = 32'h0;
    endtask

    task automatic addr_ph(input int k, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a, input logic [1:0] tr);
        hsel[k]   = 1'b1;
        htrans[k] = tr;
        hsize[k]  = sz;
        hwrite[k] = wr;
        haddr[k]  = a;
    endtask

    // Single non-pipelined transfer; reports final-cycle data/response and low cycles.
    task automatic xfer(input int k, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [1:0] resp, output int waits);
        addr_ph(k, wr, sz, a, 2'(HTRANS_NONSEQ));
        cyc();
        idle(k);
        hwdata[k] = wd;
        waits = 0;
        while (hro[k] !== 1'b1 && waits < 20) begin
            waits++;
            cyc();
        end
        if (waits >= 20) check("xfer_timeout", 32'(hro[k]), 32'h1);
        rd   = hrdata[k];
        resp = hresp[k];
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          w;
        int          beat;
        int          cycles;
        int          lows;
        logic        resp_bad;

        for (int k = 0; k < 3; k++) begin
            idle(k);
            hwdata[k] = 32'h0;
        end

        // 1: reset with random activity
        HRESETn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hsel[0]   = 1'($urandom);
            htrans[0] = 2'($urandom);
            hsize[0]  = 3'($urandom);
            hwrite[0] = 1'($urandom);
            haddr[0]  = $urandom;
            hwdata[0] = $urandom;
            cyc();
        end
        check("rst_hreadyout", 32'(hro[0]), 32'h1);
        check("rst_hresp", 32'(hresp[0]), 32'h0);
        check("rst_hrdata", hrdata[0], 32'h0);
        check("rst_hreadyout_ws3", 32'(hro[2]), 32'h1);
        idle(0);
        HRESETn = 1'b1;
        cyc();

        // 2: zero-wait word write/read
        xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, resp, w);
        check("ws0_wr_waits", 32'(w), 32'h0);
        check("ws0_wr_resp", 32'(resp), 32'h0);
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, resp, w);
        check("ws0_rd_data", rd, 32'hDEAD_BEEF);
        check("ws0_rd_waits", 32'(w), 32'h0);

        // 3: byte and halfword lanes
        xfer(0, 1'b1, 3'd2, 32'h10, 32'h1122_3344, rd, resp, w);
        xfer(0, 1'b1, 3'd0, 32'h13, 32'hAB99_8877, rd, resp, w);
        xfer(0, 1'b1, 3'd1, 32'h10, 32'hEEEE_5566, rd, resp, w);
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, resp, w);
        check("lanes_rd", rd, 32'hAB22_5566);

        // write then immediate read of the same word
        xfer(0, 1'b1, 3'd2, 32'h30, 32'h0000_0001, rd, resp, w);
        addr_ph(0, 1'b1, 3'd2, 32'h30, 2'(HTRANS_NONSEQ));
        cyc();
        hwdata[0] = 32'h0BAD_CAFE;
        addr_ph(0, 1'b0, 3'd2, 32'h30, 2'(HTRANS_NONSEQ));
        cyc();
        idle(0);
        check("hazard_ready", 32'(hro[0]), 32'h1);
        check("hazard_data", hrdata[0], 32'h0BAD_CAFE);
        cyc();
        check("hazard_after", hrdata[0], 32'h0);

        // 4: INCR4 read burst with 2 wait states
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 3'd2, 32'h20 + 32'(4 * i), 32'hA000_0000 + 32'(i), rd, resp, w);
        end
        check("ws2_wr_waits", 32'(w), 32'h2);
        addr_ph(1, 1'b0, 3'd2, 32'h20, 2'(HTRANS_NONSEQ));
        hburst[1] = 3'b011;
        cyc();
        addr_ph(1, 1'b0, 3'd2, 32'h24, 2'(HTRANS_SEQ));
        beat = 0; cycles = 0; lows = 0; resp_bad = 1'b0;
        while (beat < 4 && cycles < 40) begin
            cycles++;
            if (hresp[1] !== 2'd0) resp_bad = 1'b1;
            if (hro[1] === 1'b1) begin
                check("burst_data", hrdata[1], 32'hA000_0000 + 32'(beat));
                check("burst_waits", 32'(lows), 32'h2);
                lows = 0;
                beat++;
                cyc();
                if (beat + 1 < 4) addr_ph(1, 1'b0, 3'd2, 32'h20 + 32'(4 * (beat + 1)), 2'(HTRANS_SEQ));
                else idle(1);
            end else begin
                lows++;
                cyc();
            end
        end
        idle(1);
        check("burst_cycles", 32'(cycles), 32'd12);
        check("burst_resp", 32'(resp_bad), 32'h0);

        // 5: misaligned and out-of-region writes error out
        addr_ph(1, 1'b1, 3'd2, 32'h22, 2'(HTRANS_NONSEQ));
        cyc();
        idle(1);
        hwdata[1] = 32'hFFFF_FFFF;
        check("err1_ready", 32'(hro[1]), 32'h0);
        check("err1_resp", 32'(hresp[1]), 32'h1);
        cyc();
        check("err2_ready", 32'(hro[1]), 32'h1);
        check("err2_resp", 32'(hresp[1]), 32'h1);
        cyc();
        check("err_idle_resp", 32'(hresp[1]), 32'h0);
        check("err_idle_ready", 32'(hro[1]), 32'h1);
        xfer(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, resp, w);
        check("err_unchanged", rd, 32'hA000_0000);
        xfer(1, 1'b1, 3'd2, 32'h0000_1020, 32'hFFFF_FFFF, rd, resp, w);
        check("oor_resp", 32'(resp), 32'h1);
        check("oor_waits", 32'(w), 32'h1);
        check("oor_idle_resp", 32'(hresp[1]), 32'h0);
        xfer(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, resp, w);
        check("oor_unchanged", rd, 32'hA000_0000);

        // 6: reset during a waited write drops the write
        xfer(2, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, rd, resp, w);
        check("ws3_wr_waits", 32'(w), 32'h3);
        addr_ph(2, 1'b1, 3'd2, 32'h40, 2'(HTRANS_NONSEQ));
        cyc();
        idle(2);
        hwdata[2] = 32'h1234_5678;
        check("ws3_wait1", 32'(hro[2]), 32'h0);
        cyc();
        HRESETn = 1'b0;
        cyc();
        check("midrst_ready", 32'(hro[2]), 32'h1);
        check("midrst_resp", 32'(hresp[2]), 32'h0);
        HRESETn = 1'b1;
        xfer(2, 1'b0, 3'd2, 32'h40, 32'h0, rd, resp, w);
        check("midrst_data", rd, 32'hCAFE_F00D);
        check("ws3_rd_waits", 32'(w), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
